// File: rtl/ham_serial_secdec.sv
// Bit-serial Hamming SEC decoder with a double-buffered serial replay of the corrected frame.
// Optional HAM_SECDED_EN adds an overall parity bit (frame N+1 bits) and double-error detection.
module ham_serial_secdec #(
  parameter int R         = 3,
  parameter bit DATA_ONLY = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic datain,
  input  logic dvin,
  output logic dvout,
  output logic code,
  output logic corr,
  output logic dbl
);
  localparam int N = (1 << R) - 1;
`ifdef HAM_SECDED_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif
  localparam int FIRST = DATA_ONLY ? 3 : 1;
  localparam logic [R-1:0] LAST = R'(FL - 1);
  localparam logic [R:0]   ENDP = (R+1)'(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  logic [R-1:0] cnt;
  logic [R:0]   pos_in;
  logic [R-1:0] syn, syn_nxt, syn_p0;
  logic [N:1]   rx, obuf, obuf_n;
  logic         vld_p0;
  logic         fix, corr_n, dbl_n, corr_pend, dbl_pend;
  logic [R:0]   opos;
  state_t       state;
`ifdef HAM_SECDED_EN
  logic         par, par_p0;
`endif

  // Next output position; data-only mode skips the parity positions 2^i.
  function automatic logic [R:0] nxt(input logic [R:0] p);
    logic [R:0] q;
    q = p + (R+1)'(1);
    if (DATA_ONLY && q != ENDP && (q & (q - (R+1)'(1))) == '0)
      q = q + (R+1)'(1);
    return q;
  endfunction

  assign pos_in = {1'b0, cnt} + (R+1)'(1);

  always_comb begin
    syn_nxt = syn;
    if (datain && !pos_in[R])
      syn_nxt = syn ^ pos_in[R-1:0];
  end

  // Input stage: accumulate frame bits and syndrome; p0 holds the completed frame's result
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      syn    <= '0;
      rx     <= '0;
      vld_p0 <= 1'b0;
      syn_p0 <= '0;
`ifdef HAM_SECDED_EN
      par    <= 1'b0;
      par_p0 <= 1'b0;
`endif
    end else begin
      vld_p0 <= 1'b0;
      if (!dvin) begin
        if (!pos_in[R])
          rx[pos_in[R-1:0]] <= datain;
        if (cnt == LAST) begin
          cnt    <= '0;
          syn    <= '0;
          vld_p0 <= 1'b1;
          syn_p0 <= syn_nxt;
`ifdef HAM_SECDED_EN
          par    <= 1'b0;
          par_p0 <= par ^ datain;
`endif
        end else begin
          cnt <= cnt + R'(1);
          syn <= syn_nxt;
`ifdef HAM_SECDED_EN
          par <= par ^ datain;
`endif
        end
      end
    end
  end

  always_comb begin
    fix    = 1'b0;
    corr_n = 1'b0;
    dbl_n  = 1'b0;
`ifdef HAM_SECDED_EN
    // Odd overall parity means a single error (possibly in the parity bit itself).
    if (par_p0) begin
      corr_n = 1'b1;
      fix    = (syn_p0 != '0);
    end else begin
      dbl_n  = (syn_p0 != '0);
    end
`else
    fix    = (syn_p0 != '0);
    corr_n = fix;
`endif
    obuf_n = '0;
    for (int p = 1; p <= N; p++)
      obuf_n[p] = rx[p] ^ (fix && (syn_p0 == R'(p)));
  end

  // Output stage: buffer load, then serial burst; a new load may coincide with the last bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      opos      <= (R+1)'(FIRST);
      obuf      <= '0;
      corr_pend <= 1'b0;
      dbl_pend  <= 1'b0;
      dvout     <= 1'b1;
      code      <= 1'b0;
      corr      <= 1'b0;
      dbl       <= 1'b0;
    end else begin
      if (vld_p0) begin
        obuf      <= obuf_n;
        corr_pend <= corr_n;
        dbl_pend  <= dbl_n;
      end
      case (state)
        IDLE: if (vld_p0) state <= LOAD;
        LOAD: begin
          dvout <= 1'b0;
          code  <= obuf[FIRST];
          corr  <= corr_pend;
          dbl   <= dbl_pend;
          opos  <= nxt((R+1)'(FIRST));
          state <= SEND;
        end
        SEND: begin
          if (opos == ENDP) begin
            dvout <= 1'b1;
            code  <= 1'b0;
            corr  <= 1'b0;
            dbl   <= 1'b0;
            state <= vld_p0 ? LOAD : IDLE;
          end else begin
            code <= obuf[opos[R-1:0]];
            opos <= nxt(opos);
            if (vld_p0) state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ham_serial_secdec.sv
// Bench for ham_serial_secdec (R=3): full-output and data-only instances driven in parallel.
module tb_ham_serial_secdec;
  localparam int N = 7;
`ifdef HAM_SECDED_EN
  localparam int FL = 8;
`else
  localparam int FL = 7;
`endif
  localparam int DEPTH = 2048;

  logic clk = 1'b0, reset = 1'b0, datain = 1'b0, dvin = 1'b1;
  logic dv_f, code_f, corr_f, dbl_f, dv_d, code_d, corr_d, dbl_d;

  ham_serial_secdec #(.R(3), .DATA_ONLY(1'b0)) u_full (
    .clk(clk), .reset(reset), .datain(datain), .dvin(dvin),
    .dvout(dv_f), .code(code_f), .corr(corr_f), .dbl(dbl_f));
  ham_serial_secdec #(.R(3), .DATA_ONLY(1'b1)) u_data (
    .clk(clk), .reset(reset), .datain(datain), .dvin(dvin),
    .dvout(dv_d), .code(code_d), .corr(corr_d), .dbl(dbl_d));

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // Expected {dvout, code, corr, dbl} after each rising edge.
  logic [3:0] exp_f [DEPTH];
  logic [3:0] exp_d [DEPTH];
  int  vectors = 0, miscompares = 0;
  bit  armed = 1'b0;
  logic [63:0] cap_f, cap_d;
  int  ncap_f, ncap_d;
  logic lc_f, ld_f, lc_d, ld_d;

  always @(negedge clk) begin
    if (armed && edge_n < DEPTH) begin
      vectors++;
      if ({dv_f, code_f, corr_f, dbl_f} !== exp_f[edge_n]) begin
        miscompares++;
        $display("FAIL full_out edge %0d dvout/code/corr/dbl got %b required %b",
                 edge_n, {dv_f, code_f, corr_f, dbl_f}, exp_f[edge_n]);
      end
      vectors++;
      if ({dv_d, code_d, corr_d, dbl_d} !== exp_d[edge_n]) begin
        miscompares++;
        $display("FAIL data_out edge %0d dvout/code/corr/dbl got %b required %b",
                 edge_n, {dv_d, code_d, corr_d, dbl_d}, exp_d[edge_n]);
      end
      if (dv_f === 1'b0) begin
        cap_f = {cap_f[62:0], code_f}; ncap_f++; lc_f = corr_f; ld_f = dbl_f;
      end
      if (dv_d === 1'b0) begin
        cap_d = {cap_d[62:0], code_d}; ncap_d++; lc_d = corr_d; ld_d = dbl_d;
      end
    end
  end

  // Frame-level decode: fr[0] is position 1, fr[7] the overall parity bit (SECDED only).
  function automatic void decode(input logic [0:7] fr, output logic [0:6] cw,
                                 output logic c, output logic d);
    int s;
    s  = 0;
    cw = fr[0:6];
    for (int p = 1; p <= N; p++) if (fr[p-1]) s ^= p;
`ifdef HAM_SECDED_EN
    if (^fr) begin
      c = 1'b1; d = 1'b0;
      if (s != 0) cw[s-1] = ~cw[s-1];
    end else begin
      c = 1'b0; d = (s != 0);
    end
`else
    c = (s != 0); d = 1'b0;
    if (s != 0) cw[s-1] = ~cw[s-1];
`endif
  endfunction

  task automatic schedule(input logic [0:7] fr, input int e);
    logic [0:6] cw;
    logic c, d;
    int k;
    decode(fr, cw, c, d);
    for (int i = 0; i < N; i++) exp_f[e + 2 + i] = {1'b0, cw[i], c, d};
    k = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        exp_d[e + 2 + k] = {1'b0, cw[p-1], c, d};
        k++;
      end
  endtask

  task automatic send_frame(input logic [0:7] fr, input int nbits, input int pause_at,
                            input int pause_len);
    for (int i = 0; i < nbits; i++) begin
      datain = fr[i];
      dvin   = 1'b0;
      @(posedge clk); #1;
      if (i == FL - 1) schedule(fr, edge_n);
      if (i + 1 == pause_at) begin
        dvin = 1'b1;
        repeat (pause_len) @(posedge clk);
        #1;
      end
    end
    dvin   = 1'b1;
    datain = 1'b0;
  endtask

  task automatic idle(input int n);
    dvin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    dvin  = 1'b1;
    @(posedge clk); #1;
    for (int j = edge_n; j < DEPTH; j++) begin
      exp_f[j] = 4'b1000;
      exp_d[j] = 4'b1000;
    end
    reset = 1'b1;
  endtask

  task automatic clr_cap();
    cap_f = '0; cap_d = '0; ncap_f = 0; ncap_d = 0;
    lc_f = 1'b0; ld_f = 1'b0; lc_d = 1'b0; ld_d = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0h required %0h", name, got, want);
    end
  endtask

  initial begin
    for (int j = 0; j < DEPTH; j++) begin
      exp_f[j] = 4'b1000;
      exp_d[j] = 4'b1000;
    end
    clr_cap();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    armed = 1'b1;
    idle(2);

    // Clean codeword, continuous strobe.
    clr_cap();
    send_frame(8'b0110011_0, FL, 0, 0);
    idle(12);
    chk("t1_code", cap_f[6:0], 64'b0110011);
    chk("t1_nbits", 64'(ncap_f), 64'd7);
    chk("t1_corr", {63'd0, lc_f}, 64'd0);
    chk("t1_data", cap_d[3:0], 64'b1011);
    chk("t1_dnbits", 64'(ncap_d), 64'd4);

    // Position 5 flipped.
    clr_cap();
    send_frame(8'b0110111_0, FL, 0, 0);
    idle(12);
    chk("t2_code", cap_f[6:0], 64'b0110011);
    chk("t2_corr", {63'd0, lc_f}, 64'd1);
    chk("t2_dbl", {63'd0, ld_f}, 64'd0);
    chk("t2_data", cap_d[3:0], 64'b1011);

    // Pause after bit 3, then a second frame back-to-back.
    clr_cap();
    send_frame(8'b0110011_0, FL, 3, 3);
    send_frame(8'b0110011_0, FL, 0, 0);
    idle(14);
    chk("t4_code", cap_f[13:0], 64'b0110011_0110011);
    chk("t4_nbits", 64'(ncap_f), 64'd14);
    chk("t4_dnbits", 64'(ncap_d), 64'd8);

    // Back-to-back frames, second one corrected: corr must switch between bursts.
    clr_cap();
    send_frame(8'b0110011_0, FL, 0, 0);
    send_frame(8'b1110011_0, FL, 0, 0);
    idle(14);
    chk("t4b_code", cap_f[13:0], 64'b0110011_0110011);
    chk("t4b_corr", {63'd0, lc_f}, 64'd1);

    // Reset mid input frame and mid output burst.
    send_frame(8'b0110011_0, FL, 0, 0);
    send_frame(8'b1100110_0, 4, 0, 0);
    do_reset();
    clr_cap();
    idle(2);
    chk("t5_abort", 64'(ncap_f), 64'd0);
    send_frame(8'b0110111_0, FL, 0, 0);
    idle(12);
    chk("t5_code", cap_f[6:0], 64'b0110011);
    chk("t5_nbits", 64'(ncap_f), 64'd7);
    chk("t5_corr", {63'd0, lc_f}, 64'd1);

`ifdef HAM_SECDED_EN
    clr_cap();
    send_frame(8'b1010011_0, FL, 0, 0);
    idle(12);
    chk("t6_dbl_code", cap_f[6:0], 64'b1010011);
    chk("t6_dbl", {63'd0, ld_f}, 64'd1);
    chk("t6_dbl_corr", {63'd0, lc_f}, 64'd0);
    clr_cap();
    send_frame(8'b0110011_1, FL, 0, 0);
    idle(12);
    chk("t6_par_code", cap_f[6:0], 64'b0110011);
    chk("t6_par_corr", {63'd0, lc_f}, 64'd1);
    chk("t6_par_dbl", {63'd0, ld_f}, 64'd0);
`endif

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
